ifetch_ctrl: RTL



---
 rtl/ifetch_pkg.sv | 32 +++
 rtl/ifetch_ctrl_fifo.sv | 51 +++++
 rtl/ifetch_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and helpers for the instruction-fetch sequencer.
package ifetch_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_MISALIGN = 2'b01,
    FC_RANGE    = 2'b10
  } fault_cause_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int INSTR_BYTES = 4;

  // Classify a fetch address; misalignment is reported ahead of range.
  function automatic fault_cause_t addr_check(input logic [31:0] addr, input int unsigned aw);
    logic [32:0] top_word;
    top_word = (33'd1 << aw) - 33'd4;
    if (addr[1:0] != 2'b00) return FC_MISALIGN;
    else if ({1'b0, addr} > top_word) return FC_RANGE;
    else return FC_NONE;
  endfunction

endpackage

// File: rtl/ifetch_ctrl_fifo.sv
// Prefetch FIFO: power-of-two depth, generic element type, flush wins
// over push/pop. Push while full is only legal together with a pop.
module fetch_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [63:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  T     din,
  output logic full,
  output logic empty,
  output T     head
);

  localparam int PW = $clog2(DEPTH);

  T mem [DEPTH];
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head  = mem[rd_ptr[PW-1:0]];

  // Read/write pointers with an extra wrap bit to tell full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage; cleared on reset so the head reads zero before any push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr[PW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fetches into a prefetch FIFO
// and hands {pc, instr} to decode. Optional perf counters are enabled
// with the IFETCH_PERF_EN macro.
//
// state | meaning
// RUN   | fetch is legal
// DRAIN | fetch stopped on a bad PC; FIFO still delivers entries
// FAULT | fetch fault reported, waiting for a redirect
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int          IMEM_AW    = 5,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        fault,
  output logic [1:0]  fault_cause
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  fetch_state_t state, state_nxt;
  fault_cause_t cause, cause_nxt;
  fault_cause_t pc_chk, redir_chk;
  logic [31:0]  pc, pc_nxt;
  logic         fifo_full, fifo_empty;
  logic         push, pop, flush;
  fetch_entry_t din, head;

  assign pc_chk    = addr_check(pc, IMEM_AW);
  assign redir_chk = addr_check(redir_pc, IMEM_AW);

  assign imem_addr   = pc;
  assign din         = {pc, imem_rdata};
  assign out_valid   = !fifo_empty;
  assign pop         = out_valid && out_ready;
  assign out_pc      = head.pc;
  assign out_instr   = head.instr;
  assign fault       = (state == FAULT);
  assign fault_cause = cause;

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH),
    .T    (fetch_entry_t)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .flush(flush),
    .din  (din),
    .full (fifo_full),
    .empty(fifo_empty),
    .head (head)
  );

  // State, PC and fault-cause registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cause <= FC_NONE;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      cause <= cause_nxt;
      pc    <= pc_nxt;
    end
  end

  // Next-state, PC advance and FIFO control; redirect overrides everything.
  always_comb begin
    state_nxt = state;
    cause_nxt = cause;
    pc_nxt    = pc;
    push      = 1'b0;
    flush     = 1'b0;
    if (redir_valid) begin
      flush     = 1'b1;
      pc_nxt    = redir_pc;
      cause_nxt = redir_chk;
      state_nxt = (redir_chk == FC_NONE) ? RUN : FAULT;
    end else begin
      case (state)
        RUN: begin
          if (pc_chk != FC_NONE) begin
            state_nxt = DRAIN;
            cause_nxt = pc_chk;
          end else if (run && (!fifo_full || pop)) begin
            push   = 1'b1;
            pc_nxt = pc + 32'(INSTR_BYTES);
          end
        end
        DRAIN: begin
          if (fifo_empty) state_nxt = FAULT;
        end
        default: ;
      endcase
    end
  end

`ifdef IFETCH_PERF_EN
  // Saturating counters of pushes and of stalled-head cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (push && (perf_fetched != 32'hFFFF_FFFF)) perf_fetched <= perf_fetched + 32'd1;
      if (out_valid && !out_ready && (perf_stall != 32'hFFFF_FFFF)) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
